// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction fetch sequencer.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [8:0] HALT_WORD = 9'h1FF;
    localparam logic [2:0] OP_BR     = 3'b101;
    localparam int         CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_branch_lut.sv
`default_nettype none
// ============================================================================
// Module  : branch_lut
// Brief   : 8-entry branch-target register file, sync write / comb read.
// Revision: 1.0
// ============================================================================
module branch_lut #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [2:0]    wr_idx,
    input  logic [AW-1:0] wr_data,
    input  logic [2:0]    rd_idx,
    output logic [AW-1:0] rd_data
);

    logic [AW-1:0] r_entries [8];

    // Read is from the registers, so a same-cycle write is seen only next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_entries[i] <= '0;
            end
        end else if (we) begin
            r_entries[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_entries[rd_idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_ctrl
// Brief   : Program counter, next-PC mux, run/halt FSM and run-cycle counter.
// Revision: 1.0
// ============================================================================
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                AW       = 8,
    parameter int                IW       = 9,
    parameter logic [AW-1:0]     RESET_PC = '0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [IW-1:0]        InstIn,
    input  logic                 LutWe,
    input  logic [2:0]           LutIdx,
    input  logic [AW-1:0]        LutData,
    output logic [AW-1:0]        InstAddress,
    output logic                 InstValid,
    output logic                 Done,
    output logic [CNT_W-1:0]     CycleCount
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    w_pc_next;
    logic [AW-1:0]    w_lut_target;
    logic [CNT_W-1:0] r_cycles;
    logic             w_is_halt;
    logic             w_take_branch;

    assign w_is_halt     = (InstIn == IW'(HALT_WORD));
    assign w_take_branch = (InstIn[IW-1 -: 3] == OP_BR) && BranchTaken;

    branch_lut #(
        .AW (AW)
    ) u_branch_lut (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (LutWe),
        .wr_idx  (LutIdx),
        .wr_data (LutData),
        .rd_idx  (InstIn[2:0]),
        .rd_data (w_lut_target)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_next = RUN;
            RUN:     if (!Stall && w_is_halt) w_state_next = HALTED;
            HALTED:  if (!Start) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        InstValid = 1'b0;
        Done      = 1'b0;
        case (r_state)
            RUN:     InstValid = 1'b1;
            HALTED:  Done      = 1'b1;
            default: ;
        endcase
    end

    // Stall outranks halt, halt outranks branch
    always_comb begin
        w_pc_next = r_pc;
        case (r_state)
            IDLE: w_pc_next = RESET_PC;
            RUN: begin
                if (Stall || w_is_halt) w_pc_next = r_pc;
                else if (w_take_branch) w_pc_next = w_lut_target;
                else                    w_pc_next = r_pc + AW'(1);
            end
            HALTED:  if (!Start) w_pc_next = RESET_PC;
            default: w_pc_next = RESET_PC;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cycles <= '0;
        end else if (r_state == IDLE && Start) begin
            r_cycles <= '0;
        end else if (r_state == RUN && r_cycles != {CNT_W{1'b1}}) begin
            r_cycles <= r_cycles + CNT_W'(1);
        end
    end

    assign InstAddress = r_pc;
    assign CycleCount  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_ctrl
// Brief   : Directed self-checking bench for inst_fetch_ctrl with a comb ROM.
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Stall;
    logic        BranchTaken;
    logic [8:0]  InstIn;
    logic        LutWe;
    logic [2:0]  LutIdx;
    logic [7:0]  LutData;
    logic [7:0]  InstAddress;
    logic        InstValid;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom [256];
    int          total = 0;
    int          bad   = 0;

    always #5 Clk = ~Clk;

    assign InstIn = rom[InstAddress];

    inst_fetch_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .InstIn      (InstIn),
        .LutWe       (LutWe),
        .LutIdx      (LutIdx),
        .LutData     (LutData),
        .InstAddress (InstAddress),
        .InstValid   (InstValid),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lut_write(input logic [2:0] idx, input logic [7:0] data);
        LutWe = 1'b1; LutIdx = idx; LutData = data;
        tick();
        LutWe = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (!Done && n < budget) begin
            tick();
            n++;
        end
        check_val("done_within_budget", {31'd0, Done}, 32'd1);
    endtask

    task automatic finish_program();
        Start = 1'b0;
        tick();
        check_val("back_to_idle_done", {31'd0, Done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
        LutWe = 1'b0; LutIdx = '0; LutData = '0;
        #12 Reset_n = 1'b1;
        tick();
        check_val("rst_addr",  {24'd0, InstAddress}, 32'h0);
        check_val("rst_valid", {31'd0, InstValid},   32'd0);
        check_val("rst_done",  {31'd0, Done},        32'd0);
        check_val("rst_cnt",   {16'd0, CycleCount},  32'd0);

        // Sequential run to halt at 4
        rom[4] = 9'h1FF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("seq_valid", {31'd0, InstValid}, 32'd1);
        for (int a = 0; a < 4; a++) begin
            check_val("seq_addr", {24'd0, InstAddress}, a);
            tick();
        end
        check_val("seq_addr4", {24'd0, InstAddress}, 32'd4);
        check_val("seq_not_done", {31'd0, Done}, 32'd0);
        tick();
        check_val("seq_done",    {31'd0, Done},        32'd1);
        check_val("seq_cnt",     {16'd0, CycleCount},  32'd5);
        check_val("seq_pc_hold", {24'd0, InstAddress}, 32'd4);
        check_val("seq_halt_invalid", {31'd0, InstValid}, 32'd0);
        finish_program();

        // Handshake: Start held through halt
        Start = 1'b1;
        tick();
        run_to_done(20);
        tick();
        check_val("hs_hold_done", {31'd0, Done}, 32'd1);
        check_val("hs_hold_pc",   {24'd0, InstAddress}, 32'd4);
        Start = 1'b0;
        tick();
        check_val("hs_idle_done", {31'd0, Done}, 32'd0);
        check_val("hs_idle_pc",   {24'd0, InstAddress}, 32'd0);
        Start = 1'b1;
        tick();
        check_val("hs_rerun_cnt", {16'd0, CycleCount}, 32'd0);
        check_val("hs_rerun_pc",  {24'd0, InstAddress}, 32'd0);
        Start = 1'b0;
        run_to_done(20);
        finish_program();

        // Branch taken / not taken
        lut_write(3'd2, 8'h40);
        rom[1] = 9'b101_000_010;
        rom[8'h40] = 9'h1FF;
        BranchTaken = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        tick();
        check_val("br_taken_pc", {24'd0, InstAddress}, 32'h40);
        run_to_done(20);
        finish_program();
        BranchTaken = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        tick();
        check_val("br_not_taken_pc", {24'd0, InstAddress}, 32'h2);
        run_to_done(20);
        finish_program();

        // Stall at a halt word
        rom[1] = 9'h000;
        rom[2] = 9'h1FF;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        tick();
        check_val("stall_pc_pre", {24'd0, InstAddress}, 32'd2);
        Stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_val("stall_pc",   {24'd0, InstAddress}, 32'd2);
            check_val("stall_done", {31'd0, Done},        32'd0);
        end
        check_val("stall_cnt", {16'd0, CycleCount}, 32'd5);
        Stall = 1'b0;
        tick();
        check_val("stall_release_done", {31'd0, Done},        32'd1);
        check_val("stall_release_cnt",  {16'd0, CycleCount},  32'd6);
        check_val("stall_release_pc",   {24'd0, InstAddress}, 32'd2);
        finish_program();

        // PC wrap FE -> FF -> 00
        rom[2] = 9'h000;
        lut_write(3'd0, 8'hFE);
        rom[1] = 9'b101_000_000;
        BranchTaken = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        tick();
        check_val("wrap_fe", {24'd0, InstAddress}, 32'hFE);
        tick();
        check_val("wrap_ff", {24'd0, InstAddress}, 32'hFF);
        tick();
        check_val("wrap_00", {24'd0, InstAddress}, 32'h00);
        check_val("wrap_no_x", {31'd0, $isunknown(InstAddress)}, 32'd0);
        BranchTaken = 1'b0;
        run_to_done(20);
        finish_program();

        // Same-cycle LUT write and branch read to index 5 uses the old target
        lut_write(3'd5, 8'h10);
        rom[1] = 9'b101_000_101;
        rom[8'h10] = 9'h1FF;
        BranchTaken = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        LutWe = 1'b1; LutIdx = 3'd5; LutData = 8'h20;
        tick();
        LutWe = 1'b0;
        check_val("lut_old_target", {24'd0, InstAddress}, 32'h10);
        run_to_done(20);
        finish_program();

        // Async reset mid-run at PC 3
        rom[1] = 9'h000;
        BranchTaken = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        tick(); tick(); tick();
        check_val("mid_pc3", {24'd0, InstAddress}, 32'd3);
        #2 Reset_n = 1'b0;
        #1;
        check_val("arst_addr",  {24'd0, InstAddress}, 32'd0);
        check_val("arst_valid", {31'd0, InstValid},   32'd0);
        check_val("arst_cnt",   {16'd0, CycleCount},  32'd0);
        #3 Reset_n = 1'b1;
        // Cleared LUT: a taken branch on index 5 must land on 0
        rom[1] = 9'b101_000_101;
        BranchTaken = 1'b1;
        tick();
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        tick();
        check_val("arst_lut_cleared", {24'd0, InstAddress}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
